lbr_drain_unit: RTL
===================

# lbr_drain_unit

Sequential drain engine sitting directly downstream of the LBR unit's memory-mapped read port. On a start pulse it snapshots the LBR top-of-stack pointer, then walks the branch record ring newest-to-oldest. For each entry it reads the from-PC bank and the to-target bank and emits one {from, to} record on a valid/ready stream to the security monitor. It also flags records that may have been torn by branches committing during the walk.

## Interface
- DATA_WIDTH, 64, width of LBR entries and addresses
- LBR_SIZE, 16, ring depth; power of two, ≥2; IW = clog2(LBR_SIZE)
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; state cleared on a rising edge with reset==0
- start  in  1  drain request; sampled only in IDLE
- count  in  IW+1  entries to drain; 0 → LBR_SIZE; values >LBR_SIZE clamp to LBR_SIZE; latched with start
- branch_commit  in  1  the same qualified branch-write strobe that drives the LBR unit (~stall & next_PC_sel[1])
- lbr_req  out  2  read request to the LBR unit: 2'b10 while reading, 2'b00 otherwise; bit0 is never driven high
- lbr_addr  out  DATA_WIDTH  LBR read address; bits [IW+1:0] meaningful, upper bits 0
- lbr_data  in  DATA_WIDTH  LBR read data, combinational from lbr_addr in the same cycle
- out_valid  out  1  record valid
- out_ready  in  1  consumer accept
- out_from  out  DATA_WIDTH  branch source PC
- out_to  out  DATA_WIDTH  branch target
- out_index  out  IW  ring slot of the record
- out_last  out  1  final record of this drain
- out_torn  out  1  a branch committed during this drain before the record was read
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at drain completion

## Operation
- LBR address map: TOS_ADDR = 1<<(IW+1); from bank = {2'b00, idx}; to bank = {2'b01, idx}; TOS register holds the slot of the most recent entry.
- FSM states: IDLE, RD_TOS, RD_FROM, RD_TO, EMIT, DONE.
  - IDLE: when start=1, latch the clamped count into remaining, clear torn, then go to RD_TOS.
  - RD_TOS: drive addr=TOS_ADDR; capture idx = lbr_data[IW-1:0]; go to RD_FROM.
  - RD_FROM: drive the from-bank address; capture from_reg; go to RD_TO.
  - RD_TO: drive the to-bank address; capture to_reg; go to EMIT.
  - EMIT: out_valid=1. On out_ready: remaining−1 and idx−1 (mod LBR_SIZE, wraps 0→LBR_SIZE−1). Go to DONE if remaining was 1, else RD_FROM.
  - DONE: done=1 for one cycle, then IDLE.
- out_last = (remaining==1) in EMIT.
- torn: sticky. Set by branch_commit in any cycle of RD_TOS, RD_FROM or RD_TO. Cleared only on start acceptance or reset. out_torn presents the current sticky value during EMIT.
- start while busy is ignored; no queuing.
- Outputs out_from, out_to and out_index are stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on reset.
- Index arithmetic is IW bits, modulo LBR_SIZE. The remaining counter is IW+1 bits.

## Timing
- Reset values: state=IDLE, lbr_req=0, lbr_addr=0, out_valid=0, out_last=0, out_torn=0, out_from/out_to/out_index=0, busy=0, done=0.
- Start sampled at cycle 0:
  - cycle 1: RD_TOS
  - cycle 2: RD_FROM
  - cycle 3: RD_TO
  - cycle 4: first out_valid
- Per-record throughput is 3 cycles with out_ready held high. N records: last handshake at cycle 3N+1, done at 3N+2, busy low at 3N+3.
- lbr_req/lbr_addr are registered-state decoded (Moore); lbr_data is captured at the end of the same cycle.
- Reset asserted mid-drain: the next edge returns to IDLE with all outputs at reset values; no done pulse.

## Structure
- Shared package lbr_pkg: LBR_BANK_FROM=2'b00, LBR_BANK_TO=2'b01, LBR_REQ_READ=2'b10, lbr_tos_addr(LBR_SIZE) function, drain FSM state enum.
- Single module, no sub-module: FSM, idx/remaining counters, from/to capture registers, torn flag.

## Test plan
- Reset, then start, count=3, TOS=5, ready=1 → records at idx 5,4,3; out_last only on idx 3; done at cycle 11; lbr_addr sequence TOS_ADDR, 0x05, 0x15, 0x04, 0x14, 0x03, 0x13.
- TOS=1, count=4 → idx 1,0,15,14 (wrap); from/to values match the preloaded LBR contents.
- count=0 and count=20 → exactly 16 records; 16th has out_last=1.
- out_ready low for 5 cycles in EMIT → out_valid and data held; no extra lbr reads; resumes on ready.
- branch_commit pulse in cycle 2 of a count=2 drain → both records out_torn=1; next drain without commits → out_torn=0.
- reset=0 in cycle 3, and start while busy → IDLE next edge with all outputs zero; the busy start has no effect on count or sequence.

Source files
------------

// File: rtl/lbr_pkg.sv
// lbr_pkg
// Shared definitions for the LBR drain engine: read-port bank selects, the
// read-request encoding, the TOS register address helper and the drain FSM
// state encoding.
package lbr_pkg;

    // Bank select occupies the two bits above the slot index.
    localparam logic [1:0] LBR_BANK_FROM = 2'b00;
    localparam logic [1:0] LBR_BANK_TO   = 2'b01;

    // Read request encoding on lbr_req; bit0 (write) is never used here.
    localparam logic [1:0] LBR_REQ_READ  = 2'b10;
    localparam logic [1:0] LBR_REQ_NONE  = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_TOS  = 3'd1,
        S_RD_FROM = 3'd2,
        S_RD_TO   = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } drain_state_e;

    // The TOS register sits just above both banks: 1 << (IW+1).
    function automatic int unsigned lbr_tos_addr(input int unsigned lbr_size);
        return 32'd1 << ($clog2(lbr_size) + 1);
    endfunction

endpackage

// File: rtl/lbr_drain_unit.sv
// lbr_drain_unit
// Drains the LBR ring newest-to-oldest. On start it reads the TOS pointer,
// then for each slot reads the from bank and the to bank and emits one
// {from, to} record. Records are flagged torn if a branch committed while
// the ring was being read during this drain.
//
// Ports:
//   clock, reset       single clock, synchronous active-low reset
//   start, count       drain request and entry count (0 or >LBR_SIZE means all)
//   branch_commit      branch-write strobe that also feeds the LBR unit
//   lbr_req, lbr_addr  read request/address to the LBR unit (Moore decoded)
//   lbr_data           read data, combinational from lbr_addr
//   out_*              record stream to the security monitor
//   busy, done         activity flag and completion pulse
//   dbg_state          current FSM state, for observation only
//
// Stream handshake: a record transfers on a rising edge where out_valid and
// out_ready are both 1. Once out_valid is raised it stays high, with
// out_from/out_to/out_index/out_last/out_torn unchanged, until that transfer
// happens (only reset can withdraw it). out_valid does not depend on
// out_ready.
module lbr_drain_unit
    import lbr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LBR_SIZE   = 16,
    localparam int IW        = $clog2(LBR_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IW:0]           count,
    input  logic                  branch_commit,
    output logic [1:0]            lbr_req,
    output logic [DATA_WIDTH-1:0] lbr_addr,
    input  logic [DATA_WIDTH-1:0] lbr_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_from,
    output logic [DATA_WIDTH-1:0] out_to,
    output logic [IW-1:0]         out_index,
    output logic                  out_last,
    output logic                  out_torn,
    output logic                  busy,
    output logic                  done,
    output drain_state_e          dbg_state
);

    localparam logic [DATA_WIDTH-1:0] TOS_ADDR   = DATA_WIDTH'(lbr_tos_addr(LBR_SIZE));
    localparam logic [IW:0]           FULL_COUNT = (IW+1)'(LBR_SIZE);

    drain_state_e          state;
    drain_state_e          state_next;
    logic [IW-1:0]         idx;
    logic [IW:0]           remaining;
    logic [IW:0]           count_clamped;
    logic [DATA_WIDTH-1:0] from_reg;
    logic [DATA_WIDTH-1:0] to_reg;
    logic                  torn;
    logic                  reading;

    // Zero means "whole ring"; anything larger than the ring is also the whole ring.
    always_comb begin
        count_clamped = count;
        if (count == '0 || count > FULL_COUNT) begin
            count_clamped = FULL_COUNT;
        end
    end

    assign reading = (state == S_RD_TOS) || (state == S_RD_FROM) || (state == S_RD_TO);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_RD_TOS;
            S_RD_TOS:  state_next = S_RD_FROM;
            S_RD_FROM: state_next = S_RD_TO;
            S_RD_TO:   state_next = S_EMIT;
            S_EMIT: begin
                if (out_ready) begin
                    state_next = (remaining == (IW+1)'(1)) ? S_DONE : S_RD_FROM;
                end
            end
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            remaining <= '0;
            from_reg  <= '0;
            to_reg    <= '0;
            torn      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= count_clamped;
                        torn      <= 1'b0;
                    end
                end
                S_RD_TOS:  idx      <= lbr_data[IW-1:0];
                S_RD_FROM: from_reg <= lbr_data;
                S_RD_TO:   to_reg   <= lbr_data;
                S_EMIT: begin
                    if (out_ready) begin
                        remaining <= remaining - 1'b1;
                        // Walking toward older entries; wraps naturally at IW bits.
                        idx       <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
            // A commit during any ring read may have moved entries under us.
            if (reading && branch_commit) begin
                torn <= 1'b1;
            end
        end
    end

    // Read port is decoded from the registered state only.
    always_comb begin
        lbr_req  = LBR_REQ_NONE;
        lbr_addr = '0;
        case (state)
            S_RD_TOS: begin
                lbr_req  = LBR_REQ_READ;
                lbr_addr = TOS_ADDR;
            end
            S_RD_FROM: begin
                lbr_req             = LBR_REQ_READ;
                lbr_addr[IW+1:0]    = {LBR_BANK_FROM, idx};
            end
            S_RD_TO: begin
                lbr_req             = LBR_REQ_READ;
                lbr_addr[IW+1:0]    = {LBR_BANK_TO, idx};
            end
            default: ;
        endcase
    end

    assign out_valid = (state == S_EMIT);
    assign out_last  = (state == S_EMIT) && (remaining == (IW+1)'(1));
    assign out_torn  = (state == S_EMIT) && torn;
    assign out_from  = from_reg;
    assign out_to    = to_reg;
    assign out_index = idx;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule
